// File: rtl/lc3b_types.sv
// ----------------------------------------------------------------------------
// lc3b_types
// Shared types for the LC-3b memory hierarchy.
//   - Default line and address widths used by the caches and pmem_arbiter.
//   - lc3b_line        : one cache line.
//   - pmem_arb_state_t : pmem_arbiter FSM states.
//   - pmem_op_t        : latched physical-memory operation.
// ----------------------------------------------------------------------------
package lc3b_types;

    localparam int LC3B_ADDR_W     = 16;
    localparam int LC3B_LINE_W     = 128;
    localparam int LC3B_STARVE_LIM = 4;

    typedef logic [LC3B_LINE_W-1:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D
    } pmem_arb_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } pmem_op_t;

endpackage

// File: rtl/arb_pick.sv
// ----------------------------------------------------------------------------
// arb_pick
// Combinational requester picker for pmem_arbiter. Exactly one of pick_i /
// pick_d is set whenever at least one request is pending.
//   Default build       : fixed priority, D beats I.
//   PMEM_ARB_FAIR_EN    : round-robin on a tie (grant the side opposite the
//                         last grant); a starved I side always wins.
// Ports
//   i_req, d_req   in   pending requests
//   last_grant_d   in   1 = previous grant went to D   (PMEM_ARB_FAIR_EN only)
//   i_starved      in   I has hit its starvation limit (PMEM_ARB_FAIR_EN only)
//   pick_i, pick_d out  winner (one-hot or none)
// ----------------------------------------------------------------------------
module arb_pick (
    input  logic i_req,
    input  logic d_req,
`ifdef PMEM_ARB_FAIR_EN
    input  logic last_grant_d,
    input  logic i_starved,
`endif
    output logic pick_i,
    output logic pick_d
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; an unassigned path would infer a latch.
        pick_i = 1'b0;
        pick_d = 1'b0;
`ifdef PMEM_ARB_FAIR_EN
        if (i_req && d_req) begin
            if (i_starved || last_grant_d) begin
                pick_i = 1'b1;
            end else begin
                pick_d = 1'b1;
            end
        end else begin
            pick_i = i_req;
            pick_d = d_req;
        end
`else
        pick_d = d_req;
        pick_i = i_req && !d_req;
`endif
    end

endmodule

// File: rtl/pmem_arbiter.sv
// ----------------------------------------------------------------------------
// pmem_arbiter
// Shares the single physical-memory port between the I-cache (line fills)
// and the D-cache (line fills and writebacks). One whole transaction is
// granted at a time: the winner's command is latched at grant, driven to
// pmem until pmem_resp, and the response is routed back only to the winner.
// Grants are always separated by at least one IDLE cycle.
//
// Configuration macro: PMEM_ARB_FAIR_EN
//   undefined : fixed D-over-I priority.
//   defined   : round-robin tie-break plus an I-side starvation limit
//               (STARVE_LIM consecutive D grants while I waits).
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   i_read, i_addr                  icache fill request (held until i_resp)
//   i_rdata, i_resp                 icache fill data / completion pulse
//   d_read, d_write, d_addr, d_wdata dcache fill / writeback request
//   d_rdata, d_resp                 dcache fill data / completion pulse
//   pmem_read, pmem_write           physical memory strobes
//   pmem_addr, pmem_wdata           physical memory command
//   pmem_rdata, pmem_resp           physical memory data / completion
// ----------------------------------------------------------------------------
module pmem_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W     = LC3B_ADDR_W,
    parameter int LINE_W     = LC3B_LINE_W,
    parameter int STARVE_LIM = LC3B_STARVE_LIM
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    if (STARVE_LIM < 1) begin : g_bad_starve_lim
        $error("pmem_arbiter: STARVE_LIM must be at least 1");
    end

    pmem_arb_state_t   state_q, state_d;
    pmem_op_t          cmd_op_q, cmd_op_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [LINE_W-1:0] cmd_wdata_q, cmd_wdata_d;

    logic     d_req;
    pmem_op_t d_op;
    logic     pick_i, pick_d;

    // A D request with both strobes set is illegal; it resolves as a write.
    assign d_req = d_read | d_write;
    assign d_op  = d_write ? OP_WRITE : OP_READ;

`ifdef PMEM_ARB_FAIR_EN
    localparam int STARVE_W = $clog2(STARVE_LIM + 1);

    logic                last_grant_d_q, last_grant_d_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                i_starved;

    assign i_starved = (starve_cnt_q == STARVE_W'(STARVE_LIM));
`endif

    arb_pick u_arb_pick (
        .i_req        (i_read),
        .d_req        (d_req),
`ifdef PMEM_ARB_FAIR_EN
        .last_grant_d (last_grant_d_q),
        .i_starved    (i_starved),
`endif
        .pick_i       (pick_i),
        .pick_d       (pick_d)
    );

    always_comb begin
        state_d     = state_q;
        cmd_op_d    = cmd_op_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
`ifdef PMEM_ARB_FAIR_EN
        last_grant_d_d = last_grant_d_q;
        starve_cnt_d   = starve_cnt_q;
`endif
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_addr  = '0;
        pmem_wdata = '0;
        i_resp     = 1'b0;
        i_rdata    = '0;
        d_resp     = 1'b0;
        d_rdata    = '0;

        unique case (state_q)
            IDLE: begin
                // pmem_resp is ignored here: nothing is outstanding.
                if (pick_d) begin
                    state_d     = GRANT_D;
                    cmd_op_d    = d_op;
                    cmd_addr_d  = d_addr;
                    cmd_wdata_d = d_wdata;
`ifdef PMEM_ARB_FAIR_EN
                    // Only D grants taken while I is waiting count as starvation.
                    if (!i_read) begin
                        starve_cnt_d = '0;
                    end else if (!i_starved) begin
                        starve_cnt_d = starve_cnt_q + STARVE_W'(1);
                    end
`endif
                end else if (pick_i) begin
                    state_d     = GRANT_I;
                    cmd_op_d    = OP_READ;
                    cmd_addr_d  = i_addr;
                    cmd_wdata_d = '0;
`ifdef PMEM_ARB_FAIR_EN
                    starve_cnt_d = '0;
`endif
                end
            end

            GRANT_I, GRANT_D: begin
                // Command comes only from the latched copy, so a requester
                // that drops or changes its request mid-flight cannot disturb pmem.
                pmem_read  = (cmd_op_q == OP_READ);
                pmem_write = (cmd_op_q == OP_WRITE);
                pmem_addr  = cmd_addr_q;
                pmem_wdata = cmd_wdata_q;
                if (pmem_resp) begin
                    state_d = IDLE;
                    if (state_q == GRANT_I) begin
                        i_resp  = 1'b1;
                        i_rdata = pmem_rdata;
                    end else begin
                        d_resp  = 1'b1;
                        d_rdata = pmem_rdata;
                    end
`ifdef PMEM_ARB_FAIR_EN
                    last_grant_d_d = (state_q == GRANT_D);
`endif
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_op_q    <= OP_READ;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
`ifdef PMEM_ARB_FAIR_EN
            last_grant_d_q <= 1'b1;
            starve_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_op_q    <= cmd_op_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
`ifdef PMEM_ARB_FAIR_EN
            last_grant_d_q <= last_grant_d_d;
            starve_cnt_q   <= starve_cnt_d;
`endif
        end
    end

    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
                                       !(d_read && d_write));

endmodule
